// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the wide-adder result path.
//   ADDER_IN_WIDTH : adder sum width
//   SER_OUT_WIDTH  : serializer output beat width
//   SER_DEPTH      : number of results the serializer can buffer
//   ser_beats()    : beats per result for a given sum/beat width
package adder_pkg;

    localparam int unsigned ADDER_IN_WIDTH = 1024;
    localparam int unsigned SER_OUT_WIDTH  = 128;
    localparam int unsigned SER_DEPTH      = 2;

    // Serializer is idle when nothing is buffered, otherwise streaming the head.
    typedef enum logic {
        SER_EMPTY = 1'b0,
        SER_SEND  = 1'b1
    } ser_state_t;

    function automatic int unsigned ser_beats(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/adder_result_serializer_if.sv
// Beat stream from the result serializer to its consumer.
//   m_valid : beat valid            m_ready : consumer accepts the beat
//   m_data  : beat payload          m_last  : final beat of a result
//   m_cout  : carry-out of the result being streamed
interface adder_result_serializer_if #(
    parameter int unsigned OUT_WIDTH = adder_pkg::SER_OUT_WIDTH
);
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_last;
    logic                 m_cout;

    modport master (output m_valid, output m_data, output m_last, output m_cout, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, input m_cout, output m_ready);
endinterface

// File: rtl/adder_result_serializer_result_fifo.sv
// Circular buffer of DEPTH entries with concurrent push/pop.
//   clk, resetn : clock, synchronous active-low reset (storage not reset)
//   push, wdata : store wdata at the write pointer (caller guarantees room)
//   pop         : release the head entry
//   rdata       : head entry
//   count       : number of stored entries
module result_fifo #(
    parameter int unsigned WIDTH = 1025,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= bump(wp);
            if (pop)  rp <= bump(rp);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];

endmodule

// File: rtl/adder_result_serializer.sv
// Captures {Cout, S} from the non-stalling adder pipeline, buffers up to DEPTH
// results and streams each as IN_WIDTH/OUT_WIDTH beats, least-significant first.
//   clk, resetn      : clock, synchronous active-low reset
//   out_valid, S, Cout : adder result, sampled when out_valid is high
//   m                : beat stream (master side)
//   space_avail      : fewer than DEPTH results stored
//   occupancy        : number of stored results
//   overflow         : sticky, a result arrived with no room and was dropped
module adder_result_serializer
    import adder_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = ADDER_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = SER_OUT_WIDTH,
    parameter int unsigned DEPTH     = SER_DEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       out_valid,
    input  logic [IN_WIDTH-1:0]        S,
    input  logic                       Cout,
    adder_result_serializer_if.master  m,
    output logic                       space_avail,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow
);
    localparam int unsigned BEATS = ser_beats(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || DEPTH < 1) begin : g_param_check
        $fatal(1, "adder_result_serializer: IN_WIDTH must be a multiple of OUT_WIDTH and DEPTH >= 1");
    end

    logic [IN_WIDTH:0]                 head;
    logic [BEATS-1:0][OUT_WIDTH-1:0]   head_beats;
    logic [OCC_W-1:0]                  count;
    logic [BC_W-1:0]                   bc;
    ser_state_t                        state;
    logic                              last;
    logic                              hs;
    logic                              pop;
    logic                              full;
    logic                              wr;

    result_fifo #(
        .WIDTH (IN_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (wr),
        .wdata  ({Cout, S}),
        .pop    (pop),
        .rdata  (head),
        .count  (count)
    );

    assign head_beats = head[IN_WIDTH-1:0];

    always_comb begin
        state = (count == '0) ? SER_EMPTY : SER_SEND;
        last  = (bc == BC_W'(BEATS - 1));
        full  = (count == OCC_W'(DEPTH));
        hs    = (state == SER_SEND) && m.m_ready;
        pop   = hs && last;
        // A full buffer still accepts when its head leaves on this same edge.
        wr    = resetn && out_valid && (!full || pop);
    end

    always_comb begin
        m.m_valid = 1'b0;
        m.m_data  = '0;
        m.m_last  = 1'b0;
        m.m_cout  = 1'b0;
        if (state == SER_SEND) begin
            m.m_valid = 1'b1;
            m.m_data  = head_beats[bc];
            m.m_last  = last;
            m.m_cout  = head[IN_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bc       <= '0;
            overflow <= 1'b0;
        end else begin
            if (hs) bc <= last ? '0 : bc + 1'b1;
            if (out_valid && !wr) overflow <= 1'b1;
        end
    end

    assign space_avail = (count < OCC_W'(DEPTH));
    assign occupancy   = count;

endmodule

// File: tb/tb_adder_result_serializer.sv
module tb_adder_result_serializer;
    localparam int unsigned IW    = 1024;
    localparam int unsigned OW    = 128;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned BEATS = IW / OW;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        logic          cout;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          out_valid;
    logic [IW-1:0] S;
    logic          Cout;
    logic          space_avail;
    logic [1:0]    occupancy;
    logic          overflow;

    adder_result_serializer_if #(.OUT_WIDTH(OW)) bus ();

    adder_result_serializer #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .out_valid   (out_valid),
        .S           (S),
        .Cout        (Cout),
        .m           (bus),
        .space_avail (space_avail),
        .occupancy   (occupancy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference state: pending beats, results held, sticky drop flag.
    beat_t exp_q[$];
    int    nres    = 0;
    bit    ovf_m   = 1'b0;
    bit    started = 1'b0;
    int    total   = 0;
    int    bad     = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Model of the capture side: a result is kept if fewer than DEPTH remain
    // after any pop the monitor has already retired for this edge.
    always @(posedge clk) begin
        logic [IW-1:0] s_cap;
        beat_t b;
        started = 1'b1;
        if (!resetn) begin
            exp_q.delete();
            nres  = 0;
            ovf_m = 1'b0;
        end else if (out_valid) begin
            if (nres < DEPTH) begin
                s_cap = S;
                for (int i = 0; i < BEATS; i++) begin
                    b.data = OW'(s_cap >> (i * OW));
                    b.last = (i == BEATS - 1);
                    b.cout = Cout;
                    exp_q.push_back(b);
                end
                nres++;
            end else begin
                ovf_m = 1'b1;
            end
        end
    end

    // Monitor: compare presented outputs, retire a beat on handshake.
    always @(negedge clk) begin
        bit vexp;
        if (started) begin
            vexp = (exp_q.size() > 0);
            chk("m_valid", OW'(bus.m_valid), OW'(vexp));
            chk("occupancy", OW'(occupancy), OW'(nres));
            chk("space_avail", OW'(space_avail), OW'(nres < DEPTH));
            chk("overflow", OW'(overflow), OW'(ovf_m));
            if (vexp) begin
                chk("m_data", bus.m_data, exp_q[0].data);
                chk("m_last", OW'(bus.m_last), OW'(exp_q[0].last));
                chk("m_cout", OW'(bus.m_cout), OW'(exp_q[0].cout));
                if (bus.m_ready) begin
                    if (exp_q[0].last) nres--;
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_data", bus.m_data, '0);
                chk("idle_last", OW'(bus.m_last), '0);
                chk("idle_cout", OW'(bus.m_cout), '0);
            end
        end
    end

    task automatic drive(input bit ov, input bit rdy);
        out_valid   = ov;
        bus.m_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_result();
        for (int i = 0; i < IW / 32; i++) S[i*32 +: 32] = $urandom;
        Cout = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0);
        resetn = 1'b1;
        drive(1'b0, 1'b0);
    endtask

    initial begin
        resetn      = 1'b0;
        out_valid   = 1'b0;
        bus.m_ready = 1'b0;
        S           = '0;
        Cout        = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        resetn = 1'b1;
        drive(1'b0, 1'b0);

        // Single result with a recognisable slice pattern.
        for (int k = 0; k < BEATS; k++) S[k*OW +: OW] = {16{8'(k)}};
        Cout = 1'b1;
        drive(1'b1, 1'b1);
        drain();

        // Two results buffered while stalled, then streamed back to back.
        rand_result();
        drive(1'b1, 1'b0);
        rand_result();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drain();

        // Third result with the buffer full is dropped.
        for (int n = 0; n < 3; n++) begin
            rand_result();
            drive(1'b1, 1'b0);
        end
        drive(1'b0, 1'b0);
        drain();
        drive(1'b0, 1'b0);
        do_reset();

        // Full buffer, new result lands on the head's last-beat handshake.
        rand_result();
        drive(1'b1, 1'b0);
        rand_result();
        drive(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() > 0 && exp_q[0].last && nres == DEPTH) begin
                rand_result();
                drive(1'b1, 1'b1);
                break;
            end
            drive(1'b0, 1'b1);
        end
        drive(1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_result();
            drive(($urandom_range(0, 4) == 0), 1'($urandom));
        end
        drain();
        do_reset();

        // Reset while beat 3 of a result is on the bus.
        rand_result();
        drive(1'b1, 1'b1);
        for (int i = 0; i < 20 && exp_q.size() > BEATS - 3; i++) drive(1'b0, 1'b1);
        resetn = 1'b0;
        drive(1'b0, 1'b1);
        resetn = 1'b1;
        drive(1'b0, 1'b0);
        rand_result();
        drive(1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
